// File: rtl/ball_pkg.sv
// Shared types and constants for the ball physics step evaluator.
package ball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE_Y0,
        ST_PROBE_Y1,
        ST_PROBE_X0,
        ST_PROBE_X1,
        ST_RESOLVE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    typedef enum logic [1:0] {
        PRB_Y0,
        PRB_Y1,
        PRB_X0,
        PRB_X1
    } probe_idx_t;

    // Map a probe state onto the probe it evaluates; non-probe states park on Y0.
    function automatic probe_idx_t state_to_probe(state_t s);
        case (s)
            ST_PROBE_Y1: return PRB_Y1;
            ST_PROBE_X0: return PRB_X0;
            ST_PROBE_X1: return PRB_X1;
            default:     return PRB_Y0;
        endcase
    endfunction

endpackage

// File: rtl/ball_physics_if.sv
// Brick-memory lookup bus: request with probe pixel, ack with brick health and origin.
interface ball_physics_if #(
    parameter int COORD_W  = 10,
    parameter int HEALTH_W = 2
);
    logic                mem_req;
    logic [COORD_W-1:0]  mem_x;
    logic [COORD_W-1:0]  mem_y;
    logic                mem_ack;
    logic [HEALTH_W-1:0] mem_health;
    logic [COORD_W-1:0]  mem_bx;
    logic [COORD_W-1:0]  mem_by;

    modport master (
        output mem_req, mem_x, mem_y,
        input  mem_ack, mem_health, mem_bx, mem_by
    );

    modport slave (
        input  mem_req, mem_x, mem_y,
        output mem_ack, mem_health, mem_bx, mem_by
    );
endinterface

// File: rtl/ball_probe_gen.sv
// Probe pixel generator: leading-edge pixel for the selected probe plus an
// in-field flag. Arithmetic is one bit wider than the coordinates so that
// x-1 / y-1 at the origin wraps to a huge value and lands outside the field.
module ball_probe_gen
    import ball_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int X_MAX     = 320,
    parameter int Y_MAX     = 240,
    parameter int BALL_SIZE = 4
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_x_dir,
    input  logic               i_y_dir,
    input  probe_idx_t         i_probe,
    output logic [COORD_W-1:0] o_px,
    output logic [COORD_W-1:0] o_py,
    output logic               o_in_field
);

    localparam logic [COORD_W:0] C_BS    = (COORD_W+1)'(BALL_SIZE);
    localparam logic [COORD_W:0] C_BS_M1 = (COORD_W+1)'(BALL_SIZE - 1);
    localparam logic [COORD_W:0] C_ONE   = (COORD_W+1)'(1);
    localparam logic [COORD_W:0] C_XMAX  = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] C_YMAX  = (COORD_W+1)'(Y_MAX);

    logic [COORD_W:0] w_x;
    logic [COORD_W:0] w_y;
    logic [COORD_W:0] w_xe;
    logic [COORD_W:0] w_ye;
    logic [COORD_W:0] w_px;
    logic [COORD_W:0] w_py;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_xe = (i_x_dir == DIR_RIGHT) ? (w_x + C_BS) : (w_x - C_ONE);
    assign w_ye = (i_y_dir == DIR_DOWN)  ? (w_y + C_BS) : (w_y - C_ONE);

    // Select the probe pixel: Y probes sit on the leading row, X probes on the leading column.
    always_comb begin
        w_px = w_x;
        w_py = w_ye;
        case (i_probe)
            PRB_Y0: begin w_px = w_x;           w_py = w_ye;           end
            PRB_Y1: begin w_px = w_x + C_BS_M1; w_py = w_ye;           end
            PRB_X0: begin w_px = w_xe;          w_py = w_y;            end
            PRB_X1: begin w_px = w_xe;          w_py = w_y + C_BS_M1;  end
            default: begin w_px = w_x;          w_py = w_ye;           end
        endcase
    end

    assign o_in_field = (w_px < C_XMAX) && (w_py < C_YMAX);
    assign o_px       = w_px[COORD_W-1:0];
    assign o_py       = w_py[COORD_W-1:0];

endmodule

// File: rtl/ball_physics.sv
// Ball physics step evaluator. A step pulse latches the ball and platform
// position, probes up to four leading-edge pixels against the brick memory,
// then resolves wall / floor / platform / brick bounces in one cycle.
// Optional build macro BALL_SPIN_EN: platform contact steers x_dir by which
// half of the platform the ball centre lands on.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for step
// PROBE_Y0 | lookup of leading-row pixel at ball left column
// PROBE_Y1 | lookup of leading-row pixel at ball right column
// PROBE_X0 | lookup of leading-column pixel at ball top row
// PROBE_X1 | lookup of leading-column pixel at ball bottom row
// RESOLVE  | update directions, pulse done (and lost on floor)
module ball_physics
    import ball_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int X_MAX     = 320,
    parameter int Y_MAX     = 240,
    parameter int BALL_SIZE = 4,
    parameter int BRICK_W   = 16,
    parameter int BRICK_H   = 8,
    parameter int PLAT_W    = 32,
    parameter int PLAT_Y    = 224,
    parameter int HEALTH_W  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               step,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] plat_x,
    ball_physics_if.master     mem,
    output logic               x_dir,
    output logic               y_dir,
    output logic               hit_valid,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y,
    output logic               busy,
    output logic               done,
    output logic               lost
);

    localparam logic [COORD_W:0] C_BS     = (COORD_W+1)'(BALL_SIZE);
    localparam logic [COORD_W:0] C_XMAX   = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] C_YMAX   = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0] C_PLAT_W = (COORD_W+1)'(PLAT_W);
    localparam logic [COORD_W:0] C_PLAT_Y = (COORD_W+1)'(PLAT_Y);

    // A ball larger than a brick could straddle bricks the two probes per edge cannot see.
    if (BRICK_W < BALL_SIZE || BRICK_H < BALL_SIZE) begin : g_bad_cfg
        $error("ball_physics: BALL_SIZE must not exceed brick dimensions");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_plat;
    logic               r_x_dir;
    logic               r_y_dir;
    logic               r_y_hit;
    logic               r_x_hit;
    logic [COORD_W-1:0] r_ybx;
    logic [COORD_W-1:0] r_yby;
    logic               r_hit_valid;
    logic [COORD_W-1:0] r_hit_x;
    logic [COORD_W-1:0] r_hit_y;

    logic               w_accept;
    logic               w_is_probe;
    logic               w_is_y_probe;
    logic               w_adv;
    logic               w_hit;
    logic               w_same_brick;
    logic [COORD_W-1:0] w_px;
    logic [COORD_W-1:0] w_py;
    logic               w_in_field;
    logic [COORD_W:0]   w_x1;
    logic [COORD_W:0]   w_y1;
    logic [COORD_W:0]   w_plat1;
    logic               w_floor;
    logic               w_plat_contact;
    logic               w_x_dir_nxt;
    logic               w_y_dir_nxt;

    ball_probe_gen #(
        .COORD_W   (COORD_W),
        .X_MAX     (X_MAX),
        .Y_MAX     (Y_MAX),
        .BALL_SIZE (BALL_SIZE)
    ) u_probe_gen (
        .i_x        (r_x),
        .i_y        (r_y),
        .i_x_dir    (r_x_dir),
        .i_y_dir    (r_y_dir),
        .i_probe    (state_to_probe(r_state)),
        .o_px       (w_px),
        .o_py       (w_py),
        .o_in_field (w_in_field)
    );

    assign w_accept     = (r_state == ST_IDLE) && step;
    assign w_is_y_probe = (r_state == ST_PROBE_Y0) || (r_state == ST_PROBE_Y1);
    assign w_is_probe   = w_is_y_probe || (r_state == ST_PROBE_X0) || (r_state == ST_PROBE_X1);
    // Out-of-field probes never touch the bus and finish in their single cycle.
    assign w_adv        = w_is_probe && (!w_in_field || mem.mem_ack);
    assign w_hit        = w_is_probe && w_in_field && mem.mem_ack && (mem.mem_health != '0);
    assign w_same_brick = r_y_hit && (mem.mem_bx == r_ybx) && (mem.mem_by == r_yby);

    assign mem.mem_req  = w_is_probe && w_in_field;
    assign mem.mem_x    = mem.mem_req ? w_px : '0;
    assign mem.mem_y    = mem.mem_req ? w_py : '0;

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_RESOLVE);
    assign lost      = (r_state == ST_RESOLVE) && w_floor;
    assign x_dir     = r_x_dir;
    assign y_dir     = r_y_dir;
    assign hit_valid = r_hit_valid;
    assign hit_x     = r_hit_x;
    assign hit_y     = r_hit_y;

    assign w_x1    = {1'b0, r_x};
    assign w_y1    = {1'b0, r_y};
    assign w_plat1 = {1'b0, r_plat};
    assign w_floor = (w_y1 >= (C_YMAX - C_BS));
    assign w_plat_contact = (r_y_dir == DIR_DOWN) && ((w_y1 + C_BS) == C_PLAT_Y) &&
                            ((w_x1 + C_BS) > w_plat1) && (w_x1 < (w_plat1 + C_PLAT_W));

`ifdef BALL_SPIN_EN
    localparam logic [COORD_W:0] C_BS_HALF   = (COORD_W+1)'(BALL_SIZE / 2);
    localparam logic [COORD_W:0] C_PLAT_HALF = (COORD_W+1)'(PLAT_W / 2);
    logic w_spin_dir;
    assign w_spin_dir = ((w_x1 + C_BS_HALF) < (w_plat1 + C_PLAT_HALF)) ? DIR_LEFT : DIR_RIGHT;
`endif

    // Bounce resolution; walls take priority over platform spin and brick toggles.
    always_comb begin
        w_x_dir_nxt = r_x_dir;
        w_y_dir_nxt = r_y_dir;
        if (w_x1 == '0)
            w_x_dir_nxt = DIR_RIGHT;
        else if (w_x1 >= (C_XMAX - C_BS))
            w_x_dir_nxt = DIR_LEFT;
`ifdef BALL_SPIN_EN
        else if (w_plat_contact)
            w_x_dir_nxt = w_spin_dir;
`endif
        else if (r_x_hit)
            w_x_dir_nxt = ~r_x_dir;

        if (w_y1 == '0)
            w_y_dir_nxt = DIR_DOWN;
        else if (w_floor)
            w_y_dir_nxt = DIR_UP;
        else if (w_plat_contact)
            w_y_dir_nxt = DIR_UP;
        else if (r_y_hit)
            w_y_dir_nxt = ~r_y_dir;
    end

    // Next-state logic: a hit on the first probe of an edge skips the second.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (step)  w_state_nxt = ST_PROBE_Y0;
            ST_PROBE_Y0: if (w_adv) w_state_nxt = w_hit ? ST_PROBE_X0 : ST_PROBE_Y1;
            ST_PROBE_Y1: if (w_adv) w_state_nxt = ST_PROBE_X0;
            ST_PROBE_X0: if (w_adv) w_state_nxt = w_hit ? ST_RESOLVE : ST_PROBE_X1;
            ST_PROBE_X1: if (w_adv) w_state_nxt = ST_RESOLVE;
            ST_RESOLVE:  w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, step latch, hit bookkeeping and direction update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_plat      <= '0;
            r_x_dir     <= DIR_RIGHT;
            r_y_dir     <= DIR_UP;
            r_y_hit     <= 1'b0;
            r_x_hit     <= 1'b0;
            r_ybx       <= '0;
            r_yby       <= '0;
            r_hit_valid <= 1'b0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_valid <= 1'b0;

            if (w_accept) begin
                r_x     <= ball_x;
                r_y     <= ball_y;
                r_plat  <= plat_x;
                r_y_hit <= 1'b0;
                r_x_hit <= 1'b0;
            end

            if (w_hit) begin
                if (w_is_y_probe) begin
                    r_y_hit     <= 1'b1;
                    r_ybx       <= mem.mem_bx;
                    r_yby       <= mem.mem_by;
                    r_hit_valid <= 1'b1;
                    r_hit_x     <= mem.mem_bx;
                    r_hit_y     <= mem.mem_by;
                end else begin
                    r_x_hit <= 1'b1;
                    if (!w_same_brick) begin
                        r_hit_valid <= 1'b1;
                        r_hit_x     <= mem.mem_bx;
                        r_hit_y     <= mem.mem_by;
                    end
                end
            end

            if (r_state == ST_RESOLVE) begin
                r_x_dir <= w_x_dir_nxt;
                r_y_dir <= w_y_dir_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: a rectangle-based brick memory model with
// configurable ack stall, pulse monitors, and one task per scenario.
module tb_ball_physics;

    localparam int CW = 10;
`ifdef BALL_SPIN_EN
    localparam bit SPIN = 1'b1;
`else
    localparam bit SPIN = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          step   = 1'b0;
    logic [CW-1:0] ball_x = '0;
    logic [CW-1:0] ball_y = '0;
    logic [CW-1:0] plat_x = '0;
    logic          x_dir, y_dir, hit_valid, busy, done, lost;
    logic [CW-1:0] hit_x, hit_y;

    ball_physics_if #(.COORD_W(CW), .HEALTH_W(2)) mif ();

    ball_physics #(.COORD_W(CW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .step      (step),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .plat_x    (plat_x),
        .mem       (mif),
        .x_dir     (x_dir),
        .y_dir     (y_dir),
        .hit_valid (hit_valid),
        .hit_x     (hit_x),
        .hit_y     (hit_y),
        .busy      (busy),
        .done      (done),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    // Brick memory model: one rectangle of pixels reports a brick at (rbx,rby).
    int            stall_n = 0;
    int            wcnt    = 0;
    logic          rect_en = 1'b0;
    logic [CW-1:0] rx0 = '0, rx1 = '0, ry0 = '0, ry1 = '0, rbx = '0, rby = '0;
    logic [1:0]    rect_h  = 2'd0;
    logic          in_rect;

    always @(posedge clk) begin
        if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    always_comb begin
        in_rect        = rect_en && (mif.mem_x >= rx0) && (mif.mem_x <= rx1) &&
                         (mif.mem_y >= ry0) && (mif.mem_y <= ry1);
        mif.mem_ack    = mif.mem_req && (wcnt >= stall_n);
        mif.mem_health = in_rect ? rect_h : 2'd0;
        mif.mem_bx     = rbx;
        mif.mem_by     = rby;
    end

    // Pulse monitors sampled mid-cycle.
    int cyc = 0, req_cnt = 0, hit_cnt = 0, done_cnt = 0, lost_cnt = 0, done_cyc = -1;
    logic [CW-1:0] last_hx = '0, last_hy = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mif.mem_req && mif.mem_ack) req_cnt++;
        if (hit_valid) begin hit_cnt++; last_hx = hit_x; last_hy = hit_y; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (lost) lost_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic do_step(input logic [CW-1:0] bx, input logic [CW-1:0] by,
                           input logic [CW-1:0] px, output int acc);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        @(negedge clk);
        ball_x = bx; ball_y = by; plat_x = px; step = 1'b1;
        acc = cyc;
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL step_done_timeout: got no done, want done within 30 cycles"); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mif.mem_req); end
        checks++; if (x_dir !== 1'b1)       begin errors++; $display("FAIL rst_xdir: got %b want 1", x_dir); end
        checks++; if (y_dir !== 1'b0)       begin errors++; $display("FAIL rst_ydir: got %b want 0", y_dir); end
        checks++; if ({done, lost, hit_valid} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {done, lost, hit_valid}); end
        checks++; if ({mif.mem_x, mif.mem_y, hit_x, hit_y} !== '0) begin errors++; $display("FAIL rst_coords: got %h want 0", {mif.mem_x, mif.mem_y, hit_x, hit_y}); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Ball at the origin moving up-right: Y probes wrap out of field, X probes are real.
    task automatic test_origin_wall();
        int acc, r0;
        r0 = req_cnt;
        do_step(10'd0, 10'd0, 10'd0, acc);
        checks++; if (req_cnt - r0 !== 2)  begin errors++; $display("FAIL origin_reqs: got %0d want 2", req_cnt - r0); end
        checks++; if (done_cyc !== acc + 5) begin errors++; $display("FAIL origin_done_cyc: got %0d want %0d", done_cyc, acc + 5); end
        checks++; if ({x_dir, y_dir} !== 2'b11) begin errors++; $display("FAIL origin_dirs: got %b want 11", {x_dir, y_dir}); end
    endtask

    task automatic test_free_field();
        int acc, r0, h0;
        r0 = req_cnt; h0 = hit_cnt;
        do_step(10'd100, 10'd100, 10'd0, acc);
        checks++; if (req_cnt - r0 !== 4)  begin errors++; $display("FAIL free_reqs: got %0d want 4", req_cnt - r0); end
        checks++; if (done_cyc !== acc + 5) begin errors++; $display("FAIL free_done_cyc: got %0d want %0d", done_cyc, acc + 5); end
        checks++; if (hit_cnt - h0 !== 0)  begin errors++; $display("FAIL free_hits: got %0d want 0", hit_cnt - h0); end
        checks++; if ({x_dir, y_dir} !== 2'b11) begin errors++; $display("FAIL free_dirs: got %b want 11", {x_dir, y_dir}); end
    endtask

    task automatic test_platform();
        int acc;
        logic exp_x;
        exp_x = SPIN ? 1'b0 : 1'b1;
        do_step(10'd150, 10'd220, 10'd140, acc);
        checks++; if (y_dir !== 1'b0)  begin errors++; $display("FAIL plat_ydir: got %b want 0", y_dir); end
        checks++; if (x_dir !== exp_x) begin errors++; $display("FAIL plat_xdir: got %b want %b", x_dir, exp_x); end
        checks++; if (done_cyc !== acc + 5) begin errors++; $display("FAIL plat_done_cyc: got %0d want %0d", done_cyc, acc + 5); end
    endtask

    task automatic test_brick_above();
        int acc, r0, h0;
        logic exp_x;
        exp_x = x_dir;
        rect_en = 1'b1; rx0 = 10'd96; rx1 = 10'd111; ry0 = 10'd41; ry1 = 10'd49;
        rbx = 10'd96; rby = 10'd40; rect_h = 2'd2;
        r0 = req_cnt; h0 = hit_cnt;
        do_step(10'd100, 10'd50, 10'd0, acc);
        rect_en = 1'b0;
        checks++; if (hit_cnt - h0 !== 1) begin errors++; $display("FAIL above_hits: got %0d want 1", hit_cnt - h0); end
        checks++; if ({last_hx, last_hy} !== {10'd96, 10'd40}) begin errors++; $display("FAIL above_origin: got (%0d,%0d) want (96,40)", last_hx, last_hy); end
        checks++; if (req_cnt - r0 !== 3) begin errors++; $display("FAIL above_reqs: got %0d want 3", req_cnt - r0); end
        checks++; if (done_cyc !== acc + 4) begin errors++; $display("FAIL above_done_cyc: got %0d want %0d", done_cyc, acc + 4); end
        checks++; if (y_dir !== 1'b1)  begin errors++; $display("FAIL above_ydir: got %b want 1", y_dir); end
        checks++; if (x_dir !== exp_x) begin errors++; $display("FAIL above_xdir: got %b want %b", x_dir, exp_x); end
    endtask

    task automatic test_floor_wall();
        int acc, r0, l0, exp_r;
        exp_r = (x_dir == 1'b1) ? 0 : 2;
        r0 = req_cnt; l0 = lost_cnt;
        do_step(10'd316, 10'd236, 10'd0, acc);
        checks++; if (lost_cnt - l0 !== 1) begin errors++; $display("FAIL floor_lost: got %0d want 1", lost_cnt - l0); end
        checks++; if ({x_dir, y_dir} !== 2'b00) begin errors++; $display("FAIL floor_dirs: got %b want 00", {x_dir, y_dir}); end
        checks++; if (req_cnt - r0 !== exp_r) begin errors++; $display("FAIL floor_reqs: got %0d want %0d", req_cnt - r0, exp_r); end
    endtask

    task automatic test_corner_brick();
        int acc, r0, h0;
        rect_en = 1'b1; rx0 = 10'd96; rx1 = 10'd100; ry0 = 10'd41; ry1 = 10'd50;
        rbx = 10'd96; rby = 10'd40; rect_h = 2'd1;
        r0 = req_cnt; h0 = hit_cnt;
        do_step(10'd100, 10'd50, 10'd0, acc);
        rect_en = 1'b0;
        checks++; if (hit_cnt - h0 !== 1) begin errors++; $display("FAIL corner_hits: got %0d want 1", hit_cnt - h0); end
        checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL corner_reqs: got %0d want 2", req_cnt - r0); end
        checks++; if (done_cyc !== acc + 3) begin errors++; $display("FAIL corner_done_cyc: got %0d want %0d", done_cyc, acc + 3); end
        checks++; if ({x_dir, y_dir} !== 2'b11) begin errors++; $display("FAIL corner_dirs: got %b want 11", {x_dir, y_dir}); end
    endtask

    task automatic test_back_to_back();
        int acc, d0, r0;
        d0 = done_cnt; r0 = req_cnt;
        @(negedge clk);
        ball_x = 10'd100; ball_y = 10'd100; plat_x = 10'd0; step = 1'b1;
        acc = cyc;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        ball_x = 10'd200; step = 1'b1;
        checks++; if (mif.mem_x !== 10'd103) begin errors++; $display("FAIL b2b_y1_x: got %0d want 103", mif.mem_x); end
        checks++; if (mif.mem_y !== 10'd104) begin errors++; $display("FAIL b2b_y1_y: got %0d want 104", mif.mem_y); end
        @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (done_cyc !== acc + 5) begin errors++; $display("FAIL b2b_done_cyc: got %0d want %0d", done_cyc, acc + 5); end
        checks++; if (req_cnt - r0 !== 4) begin errors++; $display("FAIL b2b_reqs: got %0d want 4", req_cnt - r0); end
    endtask

    task automatic test_stall();
        int acc, r0;
        stall_n = 1;
        r0 = req_cnt;
        do_step(10'd100, 10'd100, 10'd0, acc);
        stall_n = 0;
        checks++; if (done_cyc !== acc + 9) begin errors++; $display("FAIL stall_done_cyc: got %0d want %0d", done_cyc, acc + 9); end
        checks++; if (req_cnt - r0 !== 4)  begin errors++; $display("FAIL stall_reqs: got %0d want 4", req_cnt - r0); end
    endtask

    task automatic test_reset_stall();
        int d0, h0;
        stall_n = 3;
        rect_en = 1'b1; rx0 = 10'd90; rx1 = 10'd110; ry0 = 10'd90; ry1 = 10'd110;
        rbx = 10'd96; rby = 10'd96; rect_h = 2'd3;
        d0 = done_cnt; h0 = hit_cnt;
        @(negedge clk);
        ball_x = 10'd100; ball_y = 10'd100; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({mif.mem_req, mif.mem_ack} !== 2'b10) begin errors++; $display("FAIL rs_stalled: got %b want 10", {mif.mem_req, mif.mem_ack}); end
        checks++; if ({mif.mem_x, mif.mem_y} !== {10'd100, 10'd99}) begin errors++; $display("FAIL rs_probe: got (%0d,%0d) want (100,99)", mif.mem_x, mif.mem_y); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rs_req_drop: got %b want 0", mif.mem_req); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rs_idle: got %b want 0", busy); end
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rs_no_done: got %0d want 0", done_cnt - d0); end
        checks++; if (hit_cnt - h0 !== 0)  begin errors++; $display("FAIL rs_no_hit: got %0d want 0", hit_cnt - h0); end
        checks++; if ({x_dir, y_dir} !== 2'b10) begin errors++; $display("FAIL rs_dirs: got %b want 10", {x_dir, y_dir}); end
        rect_en = 1'b0;
        stall_n = 0;
    endtask

    initial begin
        test_reset();
        test_origin_wall();
        test_free_field();
        test_platform();
        test_brick_above();
        test_floor_wall();
        test_corner_brick();
        test_back_to_back();
        test_reset();
        test_stall();
        test_reset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
